regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_pkg.sv | 16 +
 rtl/regfile_read_port.sv | 37 +++
 rtl/regfile_scoreboard.sv | 123 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register file with scoreboard: sweep FSM encoding
// and default sizing constants.
package regfile_scoreboard_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } rf_state_e;

    localparam int NB_REG_DEF   = 32;
    localparam int NB_ADDR_DEF  = 5;
    localparam int N_RD_DEF     = 2;
    localparam int ZERO_REG_DEF = 1;
    localparam int BYPASS_DEF   = 1;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: array mux, write-back forwarding and busy masking.
module regfile_read_port #(
    parameter int NB_REG   = 32,
    parameter int NB_ADDR  = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic [NB_ADDR-1:0]                     i_addr,
    input  logic [(2**NB_ADDR)-1:0][NB_REG-1:0]    i_regs,
    input  logic [(2**NB_ADDR)-1:0]                i_busy,
    input  logic                                   i_we,
    input  logic [NB_ADDR-1:0]                     i_wb_addr,
    input  logic [NB_REG-1:0]                      i_wb_data,
    output logic [NB_REG-1:0]                      o_data,
    output logic                                   o_busy
);

    logic hit;
    logic is_zero;

    assign hit     = i_we && (i_addr == i_wb_addr);
    assign is_zero = (ZERO_REG != 0) && (i_addr == '0);

    always_comb begin
        o_data = i_regs[i_addr];
        if ((BYPASS != 0) && hit) begin
            o_data = i_wb_data;
        end
        if (is_zero) begin
            o_data = '0;
        end
    end

    // A write-back landing this cycle resolves the hazard, so busy is hidden.
    assign o_busy = i_busy[i_addr] && !hit && !is_zero;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard, write-back forwarding and a
// soft-clear sweep that zeroes one register per enabled cycle.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int NB_REG   = NB_REG_DEF,
    parameter int NB_ADDR  = NB_ADDR_DEF,
    parameter int N_RD     = N_RD_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int BYPASS   = BYPASS_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_enable,
    input  logic                      i_dunit_clk_en,
    input  logic [N_RD*NB_ADDR-1:0]   i_rd_addr,
    output logic [N_RD*NB_REG-1:0]    o_rd_data,
    output logic [N_RD-1:0]           o_rd_busy,
    input  logic                      i_wb_en,
    input  logic [NB_ADDR-1:0]        i_wb_addr,
    input  logic [NB_REG-1:0]         i_wb_data,
    input  logic                      i_issue_en,
    input  logic [NB_ADDR-1:0]        i_issue_addr,
    input  logic                      i_clear,
    output logic                      o_clear_busy,
    input  logic [NB_ADDR-1:0]        i_dunit_addr,
    output logic [NB_REG-1:0]         o_dunit_reg,
    output logic                      o_dunit_busy
);

    localparam int                 N_REGS   = 2**NB_ADDR;
    localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(N_REGS - 1);

    rf_state_e                      state_q;
    logic [NB_ADDR-1:0]             idx_q;
    logic [N_REGS-1:0][NB_REG-1:0]  regs_q, regs_d;
    logic [N_REGS-1:0]              busy_q, busy_d;
    logic                           idle;
    logic                           we;
    logic                           ie;

    assign idle = (state_q == IDLE);

    // Reset is folded in so forwarding cannot leak data while reset is held.
    assign we = i_reset_n && i_wb_en && i_enable && i_dunit_clk_en && idle &&
                !((ZERO_REG != 0) && (i_wb_addr == '0));
    assign ie = i_reset_n && i_issue_en && i_enable && i_dunit_clk_en && idle &&
                !((ZERO_REG != 0) && (i_issue_addr == '0));

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (state_q == SWEEP) begin
            regs_d[idx_q] = '0;
            busy_d[idx_q] = 1'b0;
        end else begin
            if (we) begin
                regs_d[i_wb_addr] = i_wb_data;
                busy_d[i_wb_addr] = 1'b0;
            end
            // Issue after write-back: a new producer to the same register wins.
            if (ie) begin
                busy_d[i_issue_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else if (i_dunit_clk_en) begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else if (i_dunit_clk_en) begin
            case (state_q)
                IDLE: begin
                    if (i_clear) begin
                        state_q <= SWEEP;
                        idx_q   <= '0;
                    end
                end
                SWEEP: begin
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_clear_busy = (state_q == SWEEP);
    assign o_dunit_reg  = regs_q[i_dunit_addr];
    assign o_dunit_busy = busy_q[i_dunit_addr];

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        regfile_read_port #(
            .NB_REG   (NB_REG),
            .NB_ADDR  (NB_ADDR),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .i_addr    (i_rd_addr[k*NB_ADDR +: NB_ADDR]),
            .i_regs    (regs_q),
            .i_busy    (busy_q),
            .i_we      (we),
            .i_wb_addr (i_wb_addr),
            .i_wb_data (i_wb_data),
            .o_data    (o_rd_data[k*NB_REG +: NB_REG]),
            .o_busy    (o_rd_busy[k])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomized bench for regfile_scoreboard against a register-array model.
module tb_regfile_scoreboard;

    localparam int NB_REG  = 32;
    localparam int NB_ADDR = 5;
    localparam int N_RD    = 2;
    localparam int NREGS   = 32;

    logic                     i_clk = 1'b0;
    logic                     i_reset_n;
    logic                     i_enable;
    logic                     i_dunit_clk_en;
    logic [N_RD*NB_ADDR-1:0]  i_rd_addr;
    logic [N_RD*NB_REG-1:0]   o_rd_data;
    logic [N_RD-1:0]          o_rd_busy;
    logic                     i_wb_en;
    logic [NB_ADDR-1:0]       i_wb_addr;
    logic [NB_REG-1:0]        i_wb_data;
    logic                     i_issue_en;
    logic [NB_ADDR-1:0]       i_issue_addr;
    logic                     i_clear;
    logic                     o_clear_busy;
    logic [NB_ADDR-1:0]       i_dunit_addr;
    logic [NB_REG-1:0]        o_dunit_reg;
    logic                     o_dunit_busy;

    always #5 i_clk = ~i_clk;

    regfile_scoreboard #(
        .NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .N_RD(N_RD), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_enable(i_enable),
        .i_dunit_clk_en(i_dunit_clk_en), .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data), .o_rd_busy(o_rd_busy), .i_wb_en(i_wb_en),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_issue_en(i_issue_en),
        .i_issue_addr(i_issue_addr), .i_clear(i_clear), .o_clear_busy(o_clear_busy),
        .i_dunit_addr(i_dunit_addr), .o_dunit_reg(o_dunit_reg), .o_dunit_busy(o_dunit_busy)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [31:0] m_reg [NREGS];
    bit          m_busy[NREGS];
    bit          m_sweep;
    int          m_idx;

    function automatic bit m_we();
        return i_reset_n && i_wb_en && i_enable && i_dunit_clk_en && !m_sweep && (i_wb_addr != 0);
    endfunction

    function automatic bit m_ie();
        return i_reset_n && i_issue_en && i_enable && i_dunit_clk_en && !m_sweep && (i_issue_addr != 0);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
        m_sweep = 1'b0;
        m_idx   = 0;
    endtask

    task automatic model_step();
        bit we, ie;
        if (!i_reset_n || !i_dunit_clk_en) return;
        if (!m_sweep) begin
            we = m_we();
            ie = m_ie();
            if (we) begin
                m_reg[i_wb_addr]  = i_wb_data;
                m_busy[i_wb_addr] = 1'b0;
            end
            if (ie) m_busy[i_issue_addr] = 1'b1;
            if (i_clear) begin
                m_sweep = 1'b1;
                m_idx   = 0;
            end
        end else begin
            m_reg[m_idx]  = '0;
            m_busy[m_idx] = 1'b0;
            if (m_idx == NREGS - 1) m_sweep = 1'b0;
            m_idx = (m_idx + 1) % NREGS;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        logic [NB_ADDR-1:0] a;
        logic [31:0]        ed;
        logic               eb;
        for (int k = 0; k < N_RD; k++) begin
            a  = i_rd_addr[k*NB_ADDR +: NB_ADDR];
            ed = (a == 0) ? 32'h0 : ((m_we() && a == i_wb_addr) ? i_wb_data : m_reg[a]);
            eb = (a != 0) && m_busy[a] && !(m_we() && a == i_wb_addr);
            chk($sformatf("%s.rd_data%0d", tag, k), o_rd_data[k*NB_REG +: NB_REG], ed);
            chk($sformatf("%s.rd_busy%0d", tag, k), {31'b0, o_rd_busy[k]}, {31'b0, eb});
        end
        chk($sformatf("%s.dunit_reg", tag), o_dunit_reg, m_reg[i_dunit_addr]);
        chk($sformatf("%s.dunit_busy", tag), {31'b0, o_dunit_busy}, {31'b0, m_busy[i_dunit_addr]});
        chk($sformatf("%s.clear_busy", tag), {31'b0, o_clear_busy}, {31'b0, m_sweep});
    endtask

    task automatic settle(input string tag);
        #3;
        chk_outputs(tag);
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic set_rd(input logic [NB_ADDR-1:0] a0, input logic [NB_ADDR-1:0] a1);
        i_rd_addr[NB_ADDR-1:0]         = a0;
        i_rd_addr[2*NB_ADDR-1:NB_ADDR] = a1;
    endtask

    task automatic set_idle();
        i_enable       = 1'b1;
        i_dunit_clk_en = 1'b1;
        i_wb_en        = 1'b0;
        i_issue_en     = 1'b0;
        i_clear        = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cb_cnt;
        i_reset_n = 1'b0;
        set_idle();
        i_wb_addr = '0; i_wb_data = '0; i_issue_addr = '0; i_dunit_addr = 5'd5;
        set_rd(5'd5, 5'd31);
        model_reset();

        // Reset state
        repeat (2) begin settle("reset"); tick(); end
        chk("reset.rd_data0", o_rd_data[31:0], 32'h0);
        chk("reset.clear_busy", {31'b0, o_clear_busy}, 32'h0);
        i_reset_n = 1'b1;
        settle("post_reset"); tick();

        // Write r5 with same-cycle forwarding, then plain read
        i_wb_en = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'hDEADBEEF;
        set_rd(5'd5, 5'd5);
        settle("wr5");
        chk("wr5.bypass0", o_rd_data[31:0], 32'hDEADBEEF);
        chk("wr5.bypass1", o_rd_data[63:32], 32'hDEADBEEF);
        chk("wr5.dunit_no_bypass", o_dunit_reg, 32'h0);
        tick();
        i_wb_en = 1'b0;
        settle("rd5");
        chk("rd5.port0", o_rd_data[31:0], 32'hDEADBEEF);
        chk("rd5.port1", o_rd_data[63:32], 32'hDEADBEEF);
        tick();

        // Register 0 is hardwired to zero and never busy
        i_wb_en = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'h1234;
        i_issue_en = 1'b1; i_issue_addr = 5'd0;
        set_rd(5'd0, 5'd0); i_dunit_addr = 5'd0;
        settle("wr0");
        chk("wr0.rd_data", o_rd_data[31:0], 32'h0);
        tick();
        set_idle();
        settle("rd0");
        chk("rd0.rd_data", o_rd_data[31:0], 32'h0);
        chk("rd0.busy", {31'b0, o_rd_busy[0]}, 32'h0);
        chk("rd0.dunit_busy", {31'b0, o_dunit_busy}, 32'h0);
        tick();

        // Issue r7, write back three cycles later
        i_issue_en = 1'b1; i_issue_addr = 5'd7; set_rd(5'd7, 5'd7); i_dunit_addr = 5'd7;
        settle("iss7");
        chk("iss7.busy_before", {31'b0, o_rd_busy[0]}, 32'h0);
        tick();
        i_issue_en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            settle("wait7");
            chk($sformatf("wait7.busy%0d", j), {31'b0, o_rd_busy[0]}, 32'h1);
            tick();
        end
        i_wb_en = 1'b1; i_wb_addr = 5'd7; i_wb_data = 32'h55;
        settle("wb7");
        chk("wb7.busy_hidden", {31'b0, o_rd_busy[1]}, 32'h0);
        chk("wb7.dunit_busy", {31'b0, o_dunit_busy}, 32'h1);
        chk("wb7.data", o_rd_data[63:32], 32'h55);
        tick();
        i_wb_en = 1'b0;
        settle("after7");
        chk("after7.data", o_rd_data[31:0], 32'h55);
        chk("after7.busy", {31'b0, o_rd_busy[0]}, 32'h0);
        tick();

        // Issue and write-back r9 together: the new producer wins
        i_wb_en = 1'b1; i_wb_addr = 5'd9; i_wb_data = 32'h9999_0009;
        i_issue_en = 1'b1; i_issue_addr = 5'd9;
        set_rd(5'd9, 5'd3); i_dunit_addr = 5'd9;
        settle("iw9"); tick();
        set_idle();
        settle("after9");
        chk("after9.busy", {31'b0, o_rd_busy[0]}, 32'h1);
        chk("after9.dunit_busy", {31'b0, o_dunit_busy}, 32'h1);
        chk("after9.data", o_rd_data[31:0], 32'h9999_0009);
        tick();

        // Fill r1..r31 with some registers issued, then sweep with a stall
        for (int r = 1; r < NREGS; r++) begin
            i_wb_en = 1'b1; i_wb_addr = NB_ADDR'(r); i_wb_data = $urandom | 32'h1;
            i_issue_en = 1'b1; i_issue_addr = NB_ADDR'((r * 7) % NREGS);
            set_rd(NB_ADDR'($urandom), NB_ADDR'(r)); i_dunit_addr = NB_ADDR'($urandom);
            settle("fill"); tick();
        end
        set_idle();
        i_clear = 1'b1;
        settle("clr"); tick();
        i_clear = 1'b0;
        cb_cnt = 0;
        for (int j = 0; j < 60; j++) begin
            i_dunit_clk_en = !(j >= 10 && j < 14);
            i_wb_en    = (j == 5);  i_wb_addr    = 5'd3; i_wb_data = 32'hBAD0_0BAD;
            i_issue_en = (j == 5);  i_issue_addr = 5'd4;
            i_clear    = (j == 20);
            set_rd(5'd3, NB_ADDR'(31 - (j % 32))); i_dunit_addr = NB_ADDR'(j % 32);
            settle("sweep");
            if (!o_clear_busy) break;
            cb_cnt++;
            tick();
        end
        set_idle();
        chk("sweep.length", cb_cnt, 36);
        for (int a = 0; a < NREGS; a++) begin
            i_dunit_addr = NB_ADDR'(a); set_rd(NB_ADDR'(a), NB_ADDR'(a));
            settle("post_sweep");
            chk($sformatf("post_sweep.reg%0d", a), o_dunit_reg, 32'h0);
            chk($sformatf("post_sweep.busy%0d", a), {31'b0, o_dunit_busy}, 32'h0);
            tick();
        end

        // Randomized traffic against the model
        for (int j = 0; j < 400; j++) begin
            i_wb_en        = $urandom_range(1, 0);
            i_wb_addr      = NB_ADDR'($urandom);
            i_wb_data      = $urandom;
            i_issue_en     = $urandom_range(1, 0);
            i_issue_addr   = NB_ADDR'($urandom);
            i_clear        = ($urandom_range(63, 0) == 0);
            i_enable       = ($urandom_range(7, 0) != 0);
            i_dunit_clk_en = ($urandom_range(7, 0) != 0);
            set_rd($urandom_range(1, 0) ? i_wb_addr : NB_ADDR'($urandom),
                   $urandom_range(1, 0) ? i_issue_addr : NB_ADDR'($urandom));
            i_dunit_addr   = $urandom_range(1, 0) ? i_wb_addr : NB_ADDR'($urandom);
            settle("rnd"); tick();
        end

        // Asynchronous reset in the middle of a sweep
        set_idle();
        for (int j = 0; j < 80 && m_sweep; j++) begin settle("drain"); tick(); end
        chk("drain.clear_busy", {31'b0, o_clear_busy}, 32'h0);
        i_wb_en = 1'b1; i_wb_addr = 5'd31; i_wb_data = 32'hA5A5_A5A5;
        settle("wr31"); tick();
        i_wb_en = 1'b0; i_clear = 1'b1;
        settle("clr2"); tick();
        i_clear = 1'b0;
        set_rd(5'd31, 5'd31); i_dunit_addr = 5'd31;
        repeat (5) begin settle("sweep2"); tick(); end
        #1;
        chk("pre_rst.data", o_rd_data[31:0], 32'hA5A5_A5A5);
        chk("pre_rst.clear_busy", {31'b0, o_clear_busy}, 32'h1);
        #1;
        i_reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst.rd0", o_rd_data[31:0], 32'h0);
        chk("async_rst.rd1", o_rd_data[63:32], 32'h0);
        chk("async_rst.dunit", o_dunit_reg, 32'h0);
        chk("async_rst.clear_busy", {31'b0, o_clear_busy}, 32'h0);
        @(posedge i_clk); #1;
        settle("in_rst"); tick();
        i_reset_n = 1'b1;
        settle("rel"); tick();
        i_wb_en = 1'b1; i_wb_addr = 5'd31; i_wb_data = 32'h77;
        settle("wr_after_rst"); tick();
        i_wb_en = 1'b0;
        settle("rd_after_rst");
        chk("rd_after_rst.data", o_rd_data[31:0], 32'h77);
        chk("rd_after_rst.clear_busy", {31'b0, o_clear_busy}, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
